jt6295_sched: RTL
=================

# jt6295_sched

Channel scheduler for the JT6295 ADPCM core. It time-multiplexes the four voice channels onto the single ROM port and the single ADPCM decoder. It is paced by the sample-rate enables `cen_sr` and `cen_sr4` produced by the core's timing generator. Per channel it holds a nibble pointer and busy flag, fetches one nibble per channel per sample period, and streams it to the decoder tagged with its channel number.

## Interface
- `AW`, 18: ROM byte-address width. Nibble pointer width is AW+1.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `cen_sr` in 1: sample-period start strobe, one `clk` wide, coincides with the first `cen_sr4`.
- `cen_sr4` in 1: slot strobe, four per sample period, one `clk` wide.
- `start` in 4: per-channel start pulse, one `clk` wide.
- `stop` in 4: per-channel stop pulse, one `clk` wide.
- `start_addr` in AW: phrase start byte address, sampled on any `start` bit.
- `end_addr` in AW: phrase end byte address, inclusive, sampled on any `start` bit.
- `rom_cs` out 1: ROM request.
- `rom_addr` out AW: ROM byte address.
- `rom_data` in 8: ROM read data.
- `rom_ok` in 1: ROM data valid.
- `dec_en` out 1: one-cycle pulse; nibble valid for the decoder.
- `dec_ch` out 2: channel of the current nibble.
- `dec_nibble` out 4: ADPCM nibble.
- `busy` out 4: channel is playing.
- `overrun` out 1: one-cycle pulse when a slot is skipped because the ROM is still busy.

## Operation
- **Slot counter `slot[1:0]`:**
  - On `cen_sr4`: cleared to 0 if `cen_sr` is also high, otherwise incremented (wraps 3→0).
  - The slot value taken at that strobe selects the channel serviced.
- **Channel record:** pointer `ptr[AW:0]` (byte address plus nibble bit), end address `eaddr[AW-1:0]`, and `busy`.
- **Start:** a `start[i]` pulse sets `ptr={start_addr,1'b0}`, `eaddr=end_addr` and `busy[i]=1`.
  - A start while the channel is already busy restarts it.
  - Several `start` bits in one cycle all load the same addresses.
- **Stop:** a `stop[i]` pulse clears `busy[i]`.
  - If `stop[i]` and `start[i]` are high in the same cycle, stop wins.
- **FSM states:**
  - IDLE: on `cen_sr4` with `busy[slot]` high, go to REQ and latch `cur_ch=slot`. Otherwise stay in IDLE.
  - REQ: `rom_cs=1`, `rom_addr=ptr[cur_ch][AW:1]`. On an accepted `rom_ok`, go to EMIT and latch `rom_data`.
  - EMIT: one cycle. Pulse `dec_en` and drive `dec_ch=cur_ch`.
    - `dec_nibble` is `rom_data[7:4]` when `ptr[0]==0`, else `rom_data[3:0]` (high nibble first).
    - Then `ptr` increments, wrapping at 2^(AW+1).
    - If the pre-increment `ptr=={eaddr,1'b1}`, `busy` clears.
    - Return to IDLE.
- **Wrap-around:** `end_addr < start_addr` is legal. The pointer wraps through 0 and continues to the end address.
- **Restart mid-fetch:** a `start`/`stop` for `cur_ch` while in REQ is recorded in the channel record. The fetch completes on the bus, but EMIT is suppressed: no `dec_en` and no pointer update. The FSM returns to IDLE.
- **Slot overrun:** a `cen_sr4` while in REQ or EMIT skips that slot and pulses `overrun` on the following cycle. The skipped channel's pointer is not advanced.
- **Reset:** all outputs and state go to 0 and the FSM goes to IDLE. A reset asserted mid-fetch drops `rom_cs` on the next edge.

## Timing
- `cen_sr4` at cycle T with a busy channel → `rom_cs`/`rom_addr` registered high at T+1.
- `rom_ok` is accepted only from T+2 onward while `rom_cs` is high, which rejects a stale `rom_ok` left over from the previous address.
- Acceptance at T+k (k≥2) → `rom_cs` low and `dec_en` high at T+k+1.
- Minimum latency from `cen_sr4` to `dec_en` is 3 cycles.
- `rom_addr` is held stable for the whole time `rom_cs` is high.
- `start`/`stop` take effect on the edge after the pulse. The slot decision reads `busy` from the same edge as the strobe.
- `dec_ch`/`dec_nibble` keep their last value when `dec_en` is low.

## Structure
- **Shared package `jt6295_pkg`:**
  - state enum {IDLE, REQ, EMIT};
  - `NCH=4`;
  - `AW` default;
  - `ROM_OK_MINLAT=2`.
- **Sub-module `jt6295_sched_ch`:** instantiated four times. It holds `ptr`, `eaddr` and `busy`, and applies start/stop/advance with stop priority.
- **Top level:** slot counter, FSM, output muxing and overrun detection.

## Test plan
- **Single playback:** start ch2 with `start_addr=0x100`, `end_addr=0x101`; ROM returns 0xA5/0x3C with `rom_ok` at k=2.
  - Expect `dec_ch=2` nibbles A, 5, 3, C in successive ch2 slots.
  - `busy[2]` falls after C.
  - `rom_addr` sequence: 0x100, 0x100, 0x101, 0x101.
- **Four channels:** all four busy.
  - Expect `dec_ch` order 0, 1, 2, 3 in every sample period, aligned to `cen_sr`.
- **Wrap-around:** `start_addr=0x3FFFF`, `end_addr=0x00000`.
  - Expect `rom_addr` 0x3FFFF, 0x3FFFF, 0x00000, 0x00000, then `busy` clears.
- **Priority and restart:** `start[1]` and `stop[1]` in the same cycle → `busy[1]` stays 0. Then `start[1]` during ch1's REQ with a new address.
  - Expect no `dec_en` for that fetch.
  - The next ch1 slot fetches the new `start_addr`.
- **Slow ROM:** `rom_ok` delayed past the next `cen_sr4`.
  - Expect one `overrun` pulse and the skipped channel's pointer unchanged.
  - Also, `rom_ok` held high continuously must not be accepted before T+2.
- **Reset in REQ:** drop `rst_n` for one cycle.
  - Expect `rom_cs`, `busy`, `dec_en` and `overrun` all 0 on the next edge.
  - Slot restarts at 0 on the next `cen_sr`.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared definitions for the JT6295 channel scheduler: FSM states, channel
// count and ROM acceptance latency.
package jt6295_pkg;
  localparam int NCH           = 4;
  localparam int AW_DEF        = 18;
  localparam int ROM_OK_MINLAT = 2;

  typedef enum logic [1:0] {IDLE, REQ, EMIT} state_t;

  // High nibble is played first, so pointer bit 0 selects the low nibble.
  function automatic logic [3:0] nib_sel(input logic [7:0] d, input logic lo);
    return lo ? d[3:0] : d[7:4];
  endfunction
endpackage

// File: rtl/jt6295_sched_if.sv
// ROM port between the scheduler (master) and the sample ROM (slave).
interface jt6295_sched_if #(parameter int AW = jt6295_pkg::AW_DEF);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master(output rom_cs, rom_addr, input rom_data, rom_ok);
  modport slave (input rom_cs, rom_addr, output rom_data, rom_ok);
endinterface

// File: rtl/jt6295_sched_ch.sv
// Per-channel playback record: nibble pointer, inclusive end address, busy.
// Update priority is stop > start > advance.
module jt6295_sched_ch import jt6295_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          adv,
  output logic [AW:0]   ptr,
  output logic          busy
);
  logic [AW-1:0] eaddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      eaddr <= '0;
      busy  <= 1'b0;
    end else if (stop) begin
      busy <= 1'b0;
    end else if (start) begin
      ptr   <= {start_addr, 1'b0};
      eaddr <= end_addr;
      busy  <= 1'b1;
    end else if (adv) begin
      // Pointer wraps naturally, so end < start plays through address 0.
      ptr <= ptr + (AW+1)'(1);
      if (ptr == {eaddr, 1'b1}) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/jt6295_sched.sv
// Four-channel scheduler: one ROM nibble fetch per channel per sample period,
// streamed to the shared ADPCM decoder tagged with its channel.
module jt6295_sched import jt6295_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_sr,
  input  logic                 cen_sr4,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW-1:0]        end_addr,
  jt6295_sched_if.master       rom,
  output logic                 dec_en,
  output logic [1:0]           dec_ch,
  output logic [3:0]           dec_nibble,
  output logic [NCH-1:0]       busy,
  output logic                 overrun
);
  localparam logic [1:0] MINLAT = 2'(ROM_OK_MINLAT);

  state_t                st, st_nxt;
  logic [1:0]            slot, slot_nxt, cur_ch, req_cnt;
  logic [NCH-1:0][AW:0]  ptr;
  logic [NCH-1:0]        adv;
  logic                  take, hit_cur, req_ok, abort, kill;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    jt6295_sched_ch #(.AW(AW)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[i]),
      .stop       (stop[i]),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .adv        (adv[i]),
      .ptr        (ptr[i]),
      .busy       (busy[i])
    );
  end

  always_comb begin
    slot_nxt = cen_sr ? 2'd0 : slot + 2'd1;
    take     = cen_sr4 && busy[slot_nxt];
    hit_cur  = start[cur_ch] | stop[cur_ch];
    // Early rom_ok may belong to the previous address; ignore it.
    req_ok   = rom.rom_ok && (req_cnt >= MINLAT);
    kill     = abort | hit_cur;
    st_nxt   = st;
    adv      = '0;
    case (st)
      IDLE: if (take) st_nxt = REQ;
      REQ:  if (req_ok) st_nxt = kill ? IDLE : EMIT;
      EMIT: begin
        st_nxt      = IDLE;
        adv[cur_ch] = 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot         <= 2'd0;
      cur_ch       <= 2'd0;
      req_cnt      <= 2'd0;
      abort        <= 1'b0;
      rom.rom_cs   <= 1'b0;
      rom.rom_addr <= '0;
      dec_en       <= 1'b0;
      dec_ch       <= 2'd0;
      dec_nibble   <= 4'd0;
      overrun      <= 1'b0;
    end else begin
      if (cen_sr4) slot <= slot_nxt;
      overrun <= cen_sr4 && (st != IDLE);
      dec_en  <= 1'b0;
      case (st)
        IDLE: if (take) begin
          cur_ch       <= slot_nxt;
          rom.rom_cs   <= 1'b1;
          rom.rom_addr <= ptr[slot_nxt][AW:1];
          req_cnt      <= 2'd1;
          // A start/stop landing with the strobe already invalidates this fetch.
          abort        <= start[slot_nxt] | stop[slot_nxt];
        end
        REQ: begin
          if (req_cnt < MINLAT) req_cnt <= req_cnt + 2'd1;
          if (hit_cur) abort <= 1'b1;
          if (req_ok) begin
            rom.rom_cs <= 1'b0;
            if (!kill) begin
              dec_en     <= 1'b1;
              dec_ch     <= cur_ch;
              dec_nibble <= nib_sel(rom.rom_data, ptr[cur_ch][0]);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
